// File: rtl/regfile_mbist_ctrl_if.sv
// Register-file 1RW test-port bundle between the March C- BIST controller
// (master) and the register-file test wrapper (slave).
//   bist  : test-port mux select into the wrapper
//   csn_t : test chip select, active low
//   wen_t : test write enable, active low (1 = read)
//   a_t   : test address (wrapper maps it to physical ~a_t[ADDR_WIDTH-2:0])
//   d_t   : test write data
//   q_t   : test read data, valid the cycle after a read is issued
interface regfile_mbist_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  bist;
  logic                  csn_t;
  logic                  wen_t;
  logic [ADDR_WIDTH-1:0] a_t;
  logic [DATA_WIDTH-1:0] d_t;
  logic [DATA_WIDTH-1:0] q_t;

  modport master (
    output bist, csn_t, wen_t, a_t, d_t,
    input  q_t
  );

  modport slave (
    input  bist, csn_t, wen_t, a_t, d_t,
    output q_t
  );
endinterface

// File: rtl/regfile_mbist_ctrl.sv
// March C- memory-BIST controller for the integer register file.
// Drives the wrapper's 1RW test port with one access per cycle and compares
// each read's data on the following cycle.
//   clk, rst_n      : core clock, synchronous active-low reset
//   start_i         : start request, honoured only in IDLE or DONE
//   tp              : test-port bundle (master side)
//   busy_o          : high in SETUP/RUN/DRAIN
//   done_o          : level, high in DONE
//   fail_o          : sticky mismatch flag
//   fail_addr_o     : test address of the first mismatch
//   fail_elem_o     : March element (0-5) of the first mismatch
//   err_cnt_o       : saturating mismatch count
//
// March C- sequence (background 0 = all zeros, 1 = all ones):
//   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
// Only addresses 0..N-1 (N = 2^(ADDR_WIDTH-1)-1) are swept with the MSB
// held at 0: lower bits all-ones would land on physical x0.
module regfile_mbist_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter bit STOP_ON_FAIL = 1'b0,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  regfile_mbist_ctrl_if.master    tp,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [2:0]              fail_elem_o,
  output logic [ERRCNT_WIDTH-1:0] err_cnt_o
);

  localparam int AW = ADDR_WIDTH - 1;
  localparam logic [AW-1:0] LAST_ADDR = {{(AW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [ERRCNT_WIDTH-1:0] sat_inc(input logic [ERRCNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERRCNT_WIDTH'(1);
  endfunction

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    op_q, op_d;
  logic                    clr_res;

  logic                    elem_up;
  logic                    acc_rd;
  logic                    wr_bg;
  logic                    rd_bg;
  logic                    last_op;
  logic                    last_addr;
  logic                    mismatch;
  logic                    halt;
  logic                    issue;

  logic                    vld_p1;
  logic                    exp_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [2:0]              elem_p1;

  logic                    fail_q;
  logic [ADDR_WIDTH-1:0]   fail_addr_q;
  logic [2:0]              fail_elem_q;
  logic [ERRCNT_WIDTH-1:0] err_cnt_q;

  // Element decode: direction, op kind and background for the current access.
  always_comb begin
    elem_up   = (elem_q != 3'd3) && (elem_q != 3'd4);
    // E0 is write-only, E5 read-only; otherwise op 0 reads and op 1 writes.
    acc_rd    = (elem_q == 3'd5) || ((elem_q != 3'd0) && !op_q);
    wr_bg     = (elem_q == 3'd1) || (elem_q == 3'd3);
    rd_bg     = (elem_q == 3'd2) || (elem_q == 3'd4);
    last_op   = ((elem_q == 3'd0) || (elem_q == 3'd5)) ? 1'b1 : op_q;
    last_addr = elem_up ? (addr_q == LAST_ADDR) : (addr_q == '0);
    mismatch  = vld_p1 && (tp.q_t != {DATA_WIDTH{exp_p1}});
    // With STOP_ON_FAIL the mismatch cycle itself issues nothing.
    halt      = STOP_ON_FAIL && mismatch;
    issue     = (state_q == S_RUN) && !halt;
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    op_d    = op_q;
    clr_res = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_SETUP;
          clr_res = 1'b1;
          elem_d  = 3'd0;
          addr_d  = '0;
          op_d    = 1'b0;
        end
      end
      S_SETUP: state_d = S_RUN;
      S_RUN: begin
        if (halt) begin
          state_d = S_DRAIN;
        end else if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!last_addr) begin
            addr_d = elem_up ? addr_q + AW'(1) : addr_q - AW'(1);
          end else if (elem_q == 3'd5) begin
            state_d = S_DRAIN;
          end else begin
            elem_d = elem_q + 3'd1;
            // E3 and E4 sweep downwards, so they start from the top word.
            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q == S_SETUP) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o   = (state_q == S_DONE);
    tp.bist  = busy_o;
    tp.csn_t = !issue;
    tp.wen_t = !(issue && !acc_rd);
    tp.a_t   = issue ? {1'b0, addr_q} : '0;
    tp.d_t   = (issue && !acc_rd) ? {DATA_WIDTH{wr_bg}} : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      vld_p1      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      err_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      vld_p1  <= issue && acc_rd;
      if (clr_res) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= 3'd0;
        err_cnt_q   <= '0;
      end else if (mismatch) begin
        fail_q    <= 1'b1;
        err_cnt_q <= sat_inc(err_cnt_q);
        if (!fail_q) begin
          fail_addr_q <= addr_p1;
          fail_elem_q <= elem_p1;
        end
      end
    end
  end

  // ---- p0 -> p1: read issued; expected value and location held for compare ----
  always_ff @(posedge clk) begin
    if (issue && acc_rd) begin
      exp_p1  <= rd_bg;
      addr_p1 <= {1'b0, addr_q};
      elem_p1 <= elem_q;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_regfile_mbist_ctrl.sv
// Bench for regfile_mbist_ctrl: two controllers (STOP_ON_FAIL 0 and 1), each
// driving a behavioural register file with an optional stuck-at bit.
module tb_regfile_mbist_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int EW = 8;
  localparam int N  = (1 << (AW - 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1;
  logic busy0, done0, fail0, busy1, done1, fail1;
  logic [AW-1:0] faddr0, faddr1;
  logic [2:0]    felem0, felem1;
  logic [EW-1:0] err0, err1;

  regfile_mbist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) tp0 ();
  regfile_mbist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) tp1 ();

  regfile_mbist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STOP_ON_FAIL(1'b0), .ERRCNT_WIDTH(EW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .tp(tp0),
    .busy_o(busy0), .done_o(done0), .fail_o(fail0),
    .fail_addr_o(faddr0), .fail_elem_o(felem0), .err_cnt_o(err0)
  );

  regfile_mbist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STOP_ON_FAIL(1'b1), .ERRCNT_WIDTH(EW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .tp(tp1),
    .busy_o(busy1), .done_o(done1), .fail_o(fail1),
    .fail_addr_o(faddr1), .fail_elem_o(felem1), .err_cnt_o(err1)
  );

  // Behavioural register files with physical address ~a_t[3:0].
  bit         f_en   [2];
  logic [3:0] f_phys [2];
  int         f_bit  [2];
  logic       f_val  [2];
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];

  function automatic logic [DW-1:0] faulty(input int u, input logic [3:0] p, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (f_en[u] && (p == f_phys[u])) r[f_bit[u]] = f_val[u];
    return r;
  endfunction

  always @(posedge clk) begin
    if (tp0.bist && !tp0.csn_t) begin
      if (!tp0.wen_t) mem0[~tp0.a_t[3:0]] <= faulty(0, ~tp0.a_t[3:0], tp0.d_t);
      else            tp0.q_t <= mem0[~tp0.a_t[3:0]];
    end
  end

  always @(posedge clk) begin
    if (tp1.bist && !tp1.csn_t) begin
      if (!tp1.wen_t) mem1[~tp1.a_t[3:0]] <= faulty(1, ~tp1.a_t[3:0], tp1.d_t);
      else            tp1.q_t <= mem1[~tp1.a_t[3:0]];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic bist, csn, wen, busy, done, fail;
    logic [AW-1:0] a, faddr;
    logic [DW-1:0] d;
    logic [2:0] felem;
    logic [EW-1:0] err;
  } obs_t;

  function automatic obs_t sample(input int u);
    obs_t o;
    if (u == 0) begin
      o.bist = tp0.bist; o.csn = tp0.csn_t; o.wen = tp0.wen_t; o.a = tp0.a_t; o.d = tp0.d_t;
      o.busy = busy0; o.done = done0; o.fail = fail0; o.faddr = faddr0; o.felem = felem0; o.err = err0;
    end else begin
      o.bist = tp1.bist; o.csn = tp1.csn_t; o.wen = tp1.wen_t; o.a = tp1.a_t; o.d = tp1.d_t;
      o.busy = busy1; o.done = done1; o.fail = fail1; o.faddr = faddr1; o.felem = felem1; o.err = err1;
    end
    return o;
  endfunction

  task automatic set_start(input int u, input logic v);
    if (u == 0) start0 = v;
    else        start1 = v;
  endtask

  // Reference: the March C- access list written out from the element table.
  typedef struct {
    logic [AW-1:0] a;
    bit            wr;
    logic [DW-1:0] d;
    bit            bg;
    int            elem;
  } acc_t;
  acc_t march_q[$];

  task automatic build_march();
    bit up     [6]    = '{1, 1, 1, 0, 0, 1};
    int nops   [6]    = '{1, 2, 2, 2, 2, 1};
    bit op_wr  [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit op_bg  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    acc_t x;
    march_q.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < nops[e]; k++) begin
          x.a    = AW'(up[e] ? i : N - 1 - i);
          x.wr   = op_wr[e][k];
          x.bg   = op_bg[e][k];
          x.d    = x.wr ? {DW{x.bg}} : '0;
          x.elem = e;
          march_q.push_back(x);
        end
  endtask

  int m_err, m_nacc, m_nrd, m_nwr, m_fidx, m_done;
  bit m_fail;
  logic [AW-1:0] m_faddr;
  logic [2:0] m_felem;

  // Replays the access list on an ideal memory with the fault in logical terms.
  task automatic model(input bit stop, input bit fen, input int fla, input int fbit, input logic fval);
    logic [DW-1:0] mm [N];
    int a;
    m_err = 0; m_fail = 0; m_faddr = '0; m_felem = '0; m_fidx = -1;
    m_nacc = march_q.size(); m_nrd = 0; m_nwr = 0;
    for (int j = 0; j < march_q.size(); j++) begin
      a = int'(march_q[j].a);
      if (march_q[j].wr) begin
        mm[a] = march_q[j].d;
        if (fen && a == fla) mm[a][fbit] = fval;
      end else if (mm[a] != {DW{march_q[j].bg}}) begin
        if (!m_fail) begin
          m_fail = 1; m_faddr = march_q[j].a; m_felem = 3'(march_q[j].elem); m_fidx = j;
        end
        if (m_err < (1 << EW) - 1) m_err++;
        if (stop) begin
          m_nacc = j + 1;
          break;
        end
      end
    end
    for (int j = 0; j < m_nacc; j++) begin
      if (march_q[j].wr) m_nwr++;
      else               m_nrd++;
    end
    m_done = (stop && m_fail) ? m_fidx + 5 : 3 + 10 * N;
  endtask

  // One complete run on controller u; cycle c counts from the start edge.
  task automatic run(input int u, input bit fen, input logic [3:0] fphys, input int fbit,
                     input logic fval, input int poke);
    obs_t o;
    int nacc, nrd, nwr, seq_err, bad_addr, done_c;
    logic [AW-1:0] e3a;
    f_en[u] = fen; f_phys[u] = fphys; f_bit[u] = fbit; f_val[u] = fval;
    model(u == 1, fen, 15 - int'(fphys), fbit, fval);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    set_start(u, 1'b1);
    @(negedge clk);
    set_start(u, 1'b0);
    o = sample(u);
    check("setup_bist", o.bist, 1);
    check("setup_csn", o.csn, 1);
    check("setup_fail_clr", o.fail, 0);
    check("setup_err_clr", o.err, 0);
    nacc = 0; nrd = 0; nwr = 0; seq_err = 0; bad_addr = 0; done_c = 0; e3a = '0;
    for (int c = 2; c <= 200 && done_c == 0; c++) begin
      @(negedge clk);
      o = sample(u);
      set_start(u, c == poke);
      if (o.done) begin
        done_c = c;
      end else if (!o.csn) begin
        if (o.a[AW-1] || (o.a[AW-2:0] == '1)) bad_addr++;
        if (nacc >= m_nacc) seq_err++;
        else if (o.a !== march_q[nacc].a || (!o.wen) != march_q[nacc].wr || o.d !== march_q[nacc].d)
          seq_err++;
        if (o.wen) nrd++;
        else       nwr++;
        if (nacc == 5 * N) e3a = o.a;
        nacc++;
      end
    end
    set_start(u, 1'b0);
    check("access_seq_errors", seq_err, 0);
    check("illegal_addr", bad_addr, 0);
    check("access_count", nacc, m_nacc);
    check("read_count", nrd, m_nrd);
    check("write_count", nwr, m_nwr);
    if (m_nacc > 5 * N) check("e3_start_addr", e3a, N - 1);
    check("done_cycle", done_c, m_done);
    check("done_bist", o.bist, 0);
    check("done_busy", o.busy, 0);
    check("fail", o.fail, m_fail);
    check("err_cnt", o.err, m_err);
    check("fail_addr", o.faddr, m_faddr);
    check("fail_elem", o.felem, m_felem);
  endtask

  task automatic check_idle(input int u, input string pfx);
    obs_t o;
    o = sample(u);
    check({pfx, "_bist"}, o.bist, 0);
    check({pfx, "_csn"}, o.csn, 1);
    check({pfx, "_wen"}, o.wen, 1);
    check({pfx, "_addr"}, o.a, 0);
    check({pfx, "_busy"}, o.busy, 0);
    check({pfx, "_done"}, o.done, 0);
  endtask

  initial begin
    obs_t o;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    f_en[0] = 0; f_en[1] = 0;
    build_march();
    repeat (3) @(negedge clk);
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    o = sample(0);
    check("rst_data", o.d, 0);
    check("rst_fail", o.fail, 0);
    check("rst_err", o.err, 0);
    check("rst_faddr", o.faddr, 0);
    check("rst_felem", o.felem, 0);
    rst_n = 1'b1;

    run(0, 0, 4'd0, 0, 1'b0, 0);                      // fault-free
    run(0, 1, 4'd5, 3, 1'b0, 0);                      // phys x5 bit 3 stuck-at-0
    run(0, 0, 4'd0, 0, 1'b0, $urandom_range(10, 140)); // clears results, start in RUN ignored
    run(0, 1, 4'd1, 0, 1'b1, 0);                      // last E5 read fails (DRAIN compare)
    run(1, 1, 4'd5, 3, 1'b0, 0);                      // stop on first fail
    for (int i = 0; i < 3; i++)
      run(1, 1, 4'($urandom_range(1, 15)), $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 3; i++)
      run(0, 1, 4'($urandom_range(1, 15)), $urandom_range(0, DW - 1), 1'($urandom_range(0, 1)),
          $urandom_range(10, 140));

    // Reset mid-E3, then a full fresh run.
    f_en[0] = 0;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (85) @(negedge clk);
    o = sample(0);
    check("midrun_busy", o.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, "midrst");
    run(0, 0, 4'd0, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
